// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pkg
//  Description : Shared opcode constants, immediate format codes and the
//                datapath-width legality check for the immediate generator.
//  Revision    : 1.0  initial pipelined release
// ============================================================================
package imm_gen_pkg;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Only RV32 and RV64 datapaths are supported.
    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational RV32I/RV64I immediate decoder. Classifies the
//                opcode and sign-extends the immediate field to XLEN.
//  Revision    : 1.0  initial pipelined release
// ============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    // The *W opcodes only exist on a 64-bit datapath.
    localparam bit c_RV64 = (XLEN == 64);

    fmt_e w_fmt;

    // Opcode classification and immediate assembly; unknown opcodes yield ILL/0.
    always_comb begin
        w_fmt = FMT_ILL;
        imm   = '0;
        case (instr[6:0])
            c_OP_LOAD, c_OP_IMM, c_OP_JALR: begin
                w_fmt = FMT_I;
                imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            c_OP_IMM32: begin
                if (c_RV64) begin
                    w_fmt = FMT_I;
                    imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
                end
            end
            c_OP_STORE: begin
                w_fmt = FMT_S;
                imm   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_fmt = FMT_B;
                imm   = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt = FMT_U;
                imm   = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            end
            c_OP_JAL: begin
                w_fmt = FMT_J;
                imm   = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            end
            c_OP_REG: begin
                w_fmt = FMT_R;
            end
            c_OP_REG32: begin
                if (c_RV64) begin
                    w_fmt = FMT_R;
                end
            end
            default: begin
                w_fmt = FMT_ILL;
            end
        endcase
    end

    assign fmt = w_fmt;

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : One-stage registered immediate generator with valid/ready
//                handshake, a single-entry skid buffer and a saturating
//                illegal-opcode counter.
//  Revision    : 1.0  initial pipelined release
// ============================================================================
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    if (!xlen_legal(XLEN)) begin : g_xlen_bad
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  w_dec_imm;
    logic [2:0]       w_dec_fmt;
    logic             w_in_xfer;
    logic             w_out_free;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [2:0]       r_out_fmt;
    logic [31:0]      r_out_instr;

    logic             r_skid_full;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic [31:0]      r_skid_instr;

    logic [CNT_W-1:0] r_cnt;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (in_instr),
        .imm   (w_dec_imm),
        .fmt   (w_dec_fmt)
    );

    // The skid entry is the only thing that can block new input.
    assign in_ready   = !r_skid_full;
    assign w_in_xfer  = in_valid && !r_skid_full;
    assign w_out_free = !r_out_valid || out_ready;

    // Output register: skid entry has priority over fresh input to keep order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_fmt   <= '0;
            r_out_instr <= '0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= r_skid_imm;
                r_out_fmt   <= r_skid_fmt;
                r_out_instr <= r_skid_instr;
            end else if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_dec_imm;
                r_out_fmt   <= w_dec_fmt;
                r_out_instr <= in_instr;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Skid entry: catches a result when the output is stalled, drains when it frees.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_full  <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= '0;
            r_skid_instr <= '0;
        end else if (r_skid_full) begin
            if (w_out_free) begin
                r_skid_full <= 1'b0;
            end
        end else if (w_in_xfer && !w_out_free) begin
            r_skid_full  <= 1'b1;
            r_skid_imm   <= w_dec_imm;
            r_skid_fmt   <= w_dec_fmt;
            r_skid_instr <= in_instr;
        end
    end

    // Saturating illegal-opcode counter; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_in_xfer && (w_dec_fmt == FMT_ILL) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_fmt     = r_out_fmt;
    assign out_instr   = r_out_instr;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Scoreboard bench driving an RV32 (4-bit counter) and an RV64
//                instance of imm_gen_pipe with shared stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32, out_instr32;
    logic [2:0]  out_fmt32;
    logic [3:0]  cnt32;

    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [31:0] out_instr64;
    logic [2:0]  out_fmt64;
    logic [15:0] cnt64;

    imm_gen_pipe #(.XLEN(32), .CNT_W(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_instr(out_instr32),
        .illegal_cnt(cnt32), .cnt_clr(cnt_clr)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_instr(out_instr64),
        .illegal_cnt(cnt64), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] instr;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [3:0]  exp_cnt32 = '0;
    logic [15:0] exp_cnt64 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: immediates built arithmetically from the field definitions.
    function automatic void ref_decode(input logic [31:0] ins, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt);
        int     s;
        longint v;
        s   = int'(ins);
        v   = 0;
        fmt = 3'd7;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = longint'(s >>> 20); end
            7'h1B: if (xlen == 64) begin fmt = 3'd1; v = longint'(s >>> 20); end
            7'h23: begin
                fmt = 3'd2;
                v = longint'(s >>> 25) * 32 + longint'(ins[11:7]);
            end
            7'h63: begin
                fmt = 3'd3;
                v = longint'(s >>> 31) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h37, 7'h17: begin fmt = 3'd4; v = longint'(int'(ins & 32'hFFFF_F000)); end
            7'h6F: begin
                fmt = 3'd5;
                v = longint'(s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'h33: fmt = 3'd0;
            7'h3B: if (xlen == 64) fmt = 3'd0;
            default: fmt = 3'd7;
        endcase
        imm = 64'(v);
    endfunction

    // Present one cycle of stimulus; on acceptance push the expected result and advance the counter model.
    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic clr);
        exp_t        t;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill32, ill64;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        cnt_clr   = clr;
        #2;
        ill32 = 1'b0;
        ill64 = 1'b0;
        if (v && in_ready32) begin
            ref_decode(ins, 32, imm, fmt);
            t.imm = imm; t.fmt = fmt; t.instr = ins;
            q32.push_back(t);
            ill32 = (fmt == 3'd7);
        end
        if (v && in_ready64) begin
            ref_decode(ins, 64, imm, fmt);
            t.imm = imm; t.fmt = fmt; t.instr = ins;
            q64.push_back(t);
            ill64 = (fmt == 3'd7);
        end
        if (clr)                               exp_cnt32 = '0;
        else if (ill32 && exp_cnt32 != 4'hF)   exp_cnt32 = exp_cnt32 + 4'd1;
        if (clr)                               exp_cnt64 = '0;
        else if (ill64 && exp_cnt64 != 16'hFFFF) exp_cnt64 = exp_cnt64 + 16'd1;
    endtask

    // Assert reset between clock edges and check that every output clears at once.
    task automatic async_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_valid32", out_valid32, 0);
        check("rst_imm32",   out_imm32,   0);
        check("rst_fmt32",   out_fmt32,   0);
        check("rst_instr32", out_instr32, 0);
        check("rst_cnt32",   cnt32,       0);
        check("rst_valid64", out_valid64, 0);
        check("rst_imm64",   out_imm64,   0);
        check("rst_cnt64",   cnt64,       0);
        q32.delete();
        q64.delete();
        exp_cnt32 = '0;
        exp_cnt64 = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: occupancy, in-order payload (held steady while stalled) and counter.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                check("in_ready32",  in_ready32,  q32.size() < 2);
                check("out_valid32", out_valid32, q32.size() != 0);
                if (q32.size() != 0) begin
                    e = q32[0];
                    check("imm32",   {32'b0, out_imm32}, {32'b0, e.imm[31:0]});
                    check("fmt32",   out_fmt32,   e.fmt);
                    check("instr32", out_instr32, e.instr);
                    if (out_ready && out_valid32) void'(q32.pop_front());
                end
                check("cnt32", cnt32, exp_cnt32);

                check("in_ready64",  in_ready64,  q64.size() < 2);
                check("out_valid64", out_valid64, q64.size() != 0);
                if (q64.size() != 0) begin
                    e = q64[0];
                    check("imm64",   out_imm64,   e.imm);
                    check("fmt64",   out_fmt64,   e.fmt);
                    check("instr64", out_instr64, e.instr);
                    if (out_ready && out_valid64) void'(q64.pop_front());
                end
                check("cnt64", cnt64, exp_cnt64);
            end
        end
    end

    logic [31:0] dir_vec [10] = '{32'hF0F10083, 32'hFE010023, 32'h00208FE3, 32'h123450B7,
                                  32'hFFDFF06F, 32'h800000B7, 32'h0000007F, 32'h0000003B,
                                  32'h0000001B, 32'h00000033};
    logic [6:0]  op_tab  [12] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};

    initial begin : stimulus
        logic [31:0] r;
        logic [6:0]  op;
        int          k;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        @(negedge clk);
        #1;
        check("init_valid32", out_valid32, 0);
        check("init_cnt32",   cnt32,       0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back known vectors with the output always ready.
        for (int i = 0; i < 10; i++) drive(1'b1, dir_vec[i], 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Clear coincident with another illegal opcode.
        drive(1'b1, 32'h0000007F, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall: output, then skid fill, then third is refused; release drains in order.
        drive(1'b1, 32'h00100093, 1'b0, 1'b0);
        drive(1'b1, 32'hFE010023, 1'b0, 1'b0);
        drive(1'b1, 32'h00208FE3, 1'b0, 1'b0);
        drive(1'b1, 32'h00208FE3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h00208FE3, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Saturation of the 4-bit counter.
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) drive(1'b1, 32'hABCDE07F, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic and back-pressure.
        for (int i = 0; i < 800; i++) begin
            r  = $urandom();
            k  = $urandom_range(0, 13);
            op = (k < 12) ? op_tab[k] : r[6:0];
            drive(($urandom_range(0, 3) != 0), {r[31:7], op},
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 60) == 0));
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while the skid entry and output register are both occupied.
        drive(1'b1, 32'h123450B7, 1'b0, 1'b0);
        drive(1'b1, 32'hFFDFF06F, 1'b0, 1'b0);
        drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h00000033, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        check("drain32", q32.size(), 0);
        check("drain64", q64.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
